// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with grant tenure: an owner keeps the bus until it
// drops its request or uses up MAX_HOLD cycles, then priority rotates past it.
module rr_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N-1:0]                         req,
    output logic [N-1:0]                         gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
    output logic                                 gnt_valid,
    output logic                                 timeout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_ONE = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic          found;
        logic [IW-1:0] idx;
    } pick_t;

    state_t        state_q;
    logic [IW-1:0] ptr_q;
    logic [CW-1:0] hold_cnt_q;
    logic [N-1:0]  gnt_q;
    logic [IW-1:0] gnt_id_q;
    logic          gnt_valid_q;
    logic          timeout_q;

    // Successor index modulo N; N need not be a power of two.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == N - 1) begin
            return '0;
        end
        return i + IW'(1);
    endfunction

    // Circular first-set-bit search: start, start+1, ..., N-1, 0, ..., start-1.
    function automatic pick_t search(input logic [N-1:0] r, input logic [IW-1:0] start);
        pick_t p;
        int    k;
        p = '0;
        k = int'(start);
        for (int i = 0; i < N; i++) begin
            if (!p.found && r[k]) begin
                p.found = 1'b1;
                p.idx   = IW'(k);
            end
            k = (k == N - 1) ? 0 : k + 1;
        end
        return p;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        return N'(1) << idx;
    endfunction

    logic [IW-1:0] owner_next;
    logic [IW-1:0] search_start;
    logic          owner_req;
    logic          hold_done;
    logic          release_now;
    pick_t         pick;

    // From IDLE the search begins at ptr; on release it begins just past the
    // owner, which is exactly where ptr is about to point.
    always_comb begin
        owner_next   = next_idx(gnt_id_q);
        owner_req    = req[gnt_id_q];
        hold_done    = (hold_cnt_q == HOLD_MAX);
        release_now  = !owner_req || hold_done;
        search_start = (state_q == IDLE) ? ptr_q : owner_next;
        pick         = search(req, search_start);
    end

    // NOTE: every register here, state and outputs alike, is assigned with <=
    // and cleared by the asynchronous reset so outputs drop without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (pick.found) begin
                        state_q     <= GRANT;
                        gnt_q       <= onehot(pick.idx);
                        gnt_id_q    <= pick.idx;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= HOLD_ONE;
                    end
                end
                GRANT: begin
                    // A drop coinciding with a full tenure counts as a drop.
                    timeout_q <= owner_req && hold_done;
                    if (!release_now) begin
                        hold_cnt_q <= hold_cnt_q + HOLD_ONE;
                    end else begin
                        ptr_q <= owner_next;
                        if (pick.found) begin
                            gnt_q       <= onehot(pick.idx);
                            gnt_id_q    <= pick.idx;
                            gnt_valid_q <= 1'b1;
                            hold_cnt_q  <= HOLD_ONE;
                        end else begin
                            state_q     <= IDLE;
                            gnt_q       <= '0;
                            gnt_id_q    <= '0;
                            gnt_valid_q <= 1'b0;
                            hold_cnt_q  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
